// File: rtl/apb_decoder_n.sv
// APB address decoder and response multiplexer for one master and NSLV slaves.
// Decodes the address into equal-size regions, latches the selected slave for
// the whole transfer, and answers unmapped addresses and hung slaves itself
// with an error response so the master never stalls.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer; a setup cycle is decoded combinationally here
// ACCESS | transfer to slave sel_q in progress; waits for its ready
// ERR    | unmapped address; error response in the first enable cycle
module apb_decoder_n #(
  parameter int NSLV     = 4,
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int RGN_BITS = 5,
  parameter int TIMEOUT  = 16
) (
  input  logic               Pclk,
  input  logic               Preset,
  input  logic               Pselx,
  input  logic               Penable,
  input  logic [AW-1:0]      Paddr,
  output logic [NSLV-1:0]    Psel_s,
  output logic               Penable_s,
  input  logic [NSLV-1:0]    Pready_s,
  input  logic [NSLV*DW-1:0] Prdata_s,
  output logic               Pready,
  output logic [DW-1:0]      Prdata,
  output logic               Pslverr
);

  localparam int SW = $clog2(NSLV);
  localparam int HW = AW - RGN_BITS;
  // A zero timeout disables the counter, but it still needs a legal width.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [HW-1:0]   hit;
  logic            mapped;
  logic            slv_ready;
  logic [DW-1:0]   slv_rdata;
  logic            unused_addr;

  // The region index is the address above the region offset; indices at or
  // beyond NSLV fall outside every slave.
  assign hit         = Paddr[AW-1:RGN_BITS];
  assign mapped      = (32'(hit) < 32'(NSLV));
  assign unused_addr = ^Paddr[RGN_BITS-1:0];

  assign slv_ready = Pready_s[sel_q];
  assign slv_rdata = Prdata_s[int'(sel_q)*DW +: DW];

  function automatic logic [NSLV-1:0] onehot(input logic [SW-1:0] idx);
    logic [NSLV-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // State, latched slave index and wait counter.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode and all slave/master-facing outputs.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    Psel_s    = '0;
    Penable_s = 1'b0;
    Pready    = 1'b0;
    Prdata    = '0;
    Pslverr   = 1'b0;
    case (state_q)
      IDLE: begin
        // Penable high here is a protocol violation and is simply ignored.
        if (Pselx && !Penable) begin
          if (mapped) begin
            Psel_s  = onehot(hit[SW-1:0]);
            sel_d   = hit[SW-1:0];
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            state_d = ERR;
          end
        end
      end
      ACCESS: begin
        if (!Pselx) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          Psel_s    = onehot(sel_q);
          Penable_s = Penable;
          Pready    = slv_ready;
          Prdata    = slv_rdata;
          // A slave that answers in the last allowed cycle beats the timeout.
          if (slv_ready) begin
            state_d = IDLE;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            Pready  = 1'b1;
            Pslverr = 1'b1;
            Prdata  = '0;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ERR: begin
        if (!Pselx) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (Penable) begin
          Pready  = 1'b1;
          Pslverr = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_decoder_n.sv
// Directed bench for apb_decoder_n: reset, zero-wait reads over all slaves,
// wait states, unmapped accesses, timeout, abort and protocol violations.
module tb_apb_decoder_n;

  localparam int NSLV     = 4;
  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int RGN_BITS = 5;
  localparam int TIMEOUT  = 16;

  logic               Pclk = 1'b0;
  logic               Preset;
  logic               Pselx;
  logic               Penable;
  logic [AW-1:0]      Paddr;
  logic [NSLV-1:0]    Psel_s;
  logic               Penable_s;
  logic [NSLV-1:0]    Pready_s;
  logic [NSLV*DW-1:0] Prdata_s;
  logic               Pready;
  logic [DW-1:0]      Prdata;
  logic               Pslverr;

  int nchk = 0;
  int nerr = 0;

  always #5 Pclk = ~Pclk;

  apb_decoder_n #(
    .NSLV(NSLV), .AW(AW), .DW(DW), .RGN_BITS(RGN_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .Pclk(Pclk), .Preset(Preset), .Pselx(Pselx), .Penable(Penable),
    .Paddr(Paddr), .Psel_s(Psel_s), .Penable_s(Penable_s),
    .Pready_s(Pready_s), .Prdata_s(Prdata_s), .Pready(Pready),
    .Prdata(Prdata), .Pslverr(Pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic en, input logic [AW-1:0] a);
    Pselx   = sel;
    Penable = en;
    Paddr   = a;
  endtask

  task automatic look(input string tag, input logic [NSLV-1:0] ps, input logic ens,
                      input logic rdy, input logic [DW-1:0] rd, input logic err);
    #2;
    chk({tag, ".psel"},   32'(Psel_s),    32'(ps));
    chk({tag, ".pen_s"},  32'(Penable_s), 32'(ens));
    chk({tag, ".pready"}, 32'(Pready),    32'(rdy));
    chk({tag, ".prdata"}, 32'(Prdata),    32'(rd));
    chk({tag, ".pslverr"},32'(Pslverr),   32'(err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    Preset   = 1'b1;
    Pselx    = 1'b0;
    Penable  = 1'b0;
    Paddr    = '0;
    Pready_s = '0;
    for (int i = 0; i < NSLV; i++) Prdata_s[i*DW +: DW] = 16'(16'hA000 + i);

    repeat (2) tick();
    look("reset", 4'b0000, 0, 0, 16'h0, 0);
    Preset = 1'b0;

    // Reset in the middle of an access to slave 2.
    Pready_s = 4'b1011;
    drive(1, 0, 8'h45);
    look("rst_setup", 4'b0100, 0, 0, 16'h0, 0);
    tick();
    drive(1, 1, 8'h45);
    look("rst_acc", 4'b0100, 1, 0, 16'hA002, 0);
    Preset = 1'b1;
    tick();
    look("rst_hold1", 4'b0000, 0, 0, 16'h0, 0);
    tick();
    look("rst_hold2", 4'b0000, 0, 0, 16'h0, 0);
    Preset = 1'b0;
    Pready_s = 4'b1111;
    drive(1, 0, 8'h45);
    look("post_rst_setup", 4'b0100, 0, 0, 16'h0, 0);
    tick();
    drive(1, 1, 8'h45);
    look("post_rst_acc", 4'b0100, 1, 1, 16'hA002, 0);
    tick();

    // Back-to-back zero-wait reads over every slave.
    for (int i = 0; i < NSLV; i++) begin
      drive(1, 0, 8'(i*32 + 5));
      look("b2b_setup", 4'(1 << i), 0, 0, 16'h0, 0);
      tick();
      drive(1, 1, 8'(i*32 + 5));
      look("b2b_acc", 4'(1 << i), 1, 1, 16'(16'hA000 + i), 0);
      tick();
    end

    // Wait states on slave 1, address moved mid-access.
    Pready_s = 4'b1101;
    Prdata_s[1*DW +: DW] = 16'h1234;
    drive(1, 0, 8'h30);
    look("ws_setup", 4'b0010, 0, 0, 16'h0, 0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, (k >= 2) ? 8'h70 : 8'h30);
      look("ws_wait", 4'b0010, 1, 0, 16'h1234, 0);
      tick();
    end
    Pready_s = 4'b1111;
    look("ws_done", 4'b0010, 1, 1, 16'h1234, 0);
    tick();
    Prdata_s[1*DW +: DW] = 16'hA001;

    // Unmapped addresses.
    drive(1, 0, 8'h80);
    look("unm80_setup", 4'b0000, 0, 0, 16'h0, 0);
    tick();
    drive(1, 1, 8'h80);
    look("unm80_acc", 4'b0000, 0, 1, 16'h0, 1);
    tick();
    drive(1, 0, 8'hFF);
    look("unmFF_setup", 4'b0000, 0, 0, 16'h0, 0);
    tick();
    drive(1, 1, 8'hFF);
    look("unmFF_acc", 4'b0000, 0, 1, 16'h0, 1);
    tick();

    // Timeout on a hung slave 2, then slave answering on the last cycle.
    Pready_s = 4'b1011;
    drive(1, 0, 8'h50);
    look("to_setup", 4'b0100, 0, 0, 16'h0, 0);
    tick();
    for (int k = 1; k < TIMEOUT; k++) begin
      drive(1, 1, 8'h50);
      look("to_wait", 4'b0100, 1, 0, 16'hA002, 0);
      tick();
    end
    look("to_err", 4'b0100, 1, 1, 16'h0, 1);
    tick();
    drive(1, 0, 8'h50);
    look("to2_setup", 4'b0100, 0, 0, 16'h0, 0);
    tick();
    for (int k = 1; k < TIMEOUT; k++) begin
      drive(1, 1, 8'h50);
      look("to2_wait", 4'b0100, 1, 0, 16'hA002, 0);
      tick();
    end
    Pready_s = 4'b1111;
    look("to2_ready_wins", 4'b0100, 1, 1, 16'hA002, 0);
    tick();

    // Abort on access cycle 2, then a full timeout proves the counter restarted.
    Pready_s = 4'b1011;
    drive(1, 0, 8'h50);
    look("ab_setup", 4'b0100, 0, 0, 16'h0, 0);
    tick();
    drive(1, 1, 8'h50);
    look("ab_wait", 4'b0100, 1, 0, 16'hA002, 0);
    tick();
    drive(0, 0, 8'h50);
    look("ab_drop", 4'b0000, 0, 0, 16'h0, 0);
    tick();
    drive(1, 0, 8'h50);
    look("ab_re_setup", 4'b0100, 0, 0, 16'h0, 0);
    tick();
    for (int k = 1; k < TIMEOUT; k++) begin
      drive(1, 1, 8'h50);
      look("ab_re_wait", 4'b0100, 1, 0, 16'hA002, 0);
      tick();
    end
    look("ab_re_err", 4'b0100, 1, 1, 16'h0, 1);
    tick();

    // Enable without a setup cycle is ignored.
    Pready_s = 4'b1111;
    drive(1, 1, 8'h25);
    look("viol1", 4'b0000, 0, 0, 16'h0, 0);
    tick();
    look("viol2", 4'b0000, 0, 0, 16'h0, 0);
    tick();
    drive(0, 0, 8'h00);
    look("idle_end", 4'b0000, 0, 0, 16'h0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
